// File: rtl/mac_engine_pkg.sv
// mac_engine_pkg: shared types, widths and arithmetic helpers for mac_engine.
// Defining MAC_ENGINE_SATURATE_EN makes the adds saturate instead of wrapping.
package mac_engine_pkg;

    localparam int unsigned MAC_ENGINE_CNT_LEN = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} mac_engine_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        valid;
    } stream_t;

    // simple_mul=1 selects per-element multiply-add, 0 selects accumulation
    typedef struct packed {
        logic                          start;
        logic                          simple_mul;
        logic [4:0]                    shift;
        logic [MAC_ENGINE_CNT_LEN-1:0] len;
    } ctrl_engine_t;

    typedef struct packed {
        logic                          busy;
        logic                          done;
        logic [MAC_ENGINE_CNT_LEN-1:0] cnt;
    } flags_engine_t;

`ifdef MAC_ENGINE_SATURATE_EN
    function automatic logic [31:0] clamp32(input logic signed [63:0] x);
        return (x > 64'sh7FFFFFFF) ? 32'h7FFFFFFF :
               (x < -64'sh80000000) ? 32'h80000000 : x[31:0];
    endfunction
`endif

    function automatic logic [31:0] add32(input logic [31:0] x, input logic [31:0] y);
`ifdef MAC_ENGINE_SATURATE_EN
        return clamp32({{32{x[31]}}, x} + {{32{y[31]}}, y});
`else
        return x + y;
`endif
    endfunction

endpackage

// File: rtl/mac_engine_mult.sv
// mac_engine_mult: registered signed 32x32 multiply with arithmetic right shift and a valid/ready stage.
// With MAC_ENGINE_SATURATE_EN the shifted product saturates to 32 bits, otherwise it is truncated.
module mac_engine_mult
    import mac_engine_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [4:0]  shift_i,
    input  logic        last_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] p_o,
    output logic [31:0] c_o,
    output logic        last_o
);
    logic signed [63:0] prod_sh;
    logic [31:0]        p_d;
    logic               valid_q, last_q;
    logic [31:0]        p_q, c_q;

    assign prod_sh = ($signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i})) >>> shift_i;
`ifdef MAC_ENGINE_SATURATE_EN
    assign p_d = clamp32(prod_sh);
`else
    logic unused_hi;
    assign p_d       = prod_sh[31:0];
    assign unused_hi = ^prod_sh[63:32];
`endif

    assign ready_o = enable_i & (~valid_q | ready_i);
    assign valid_o = valid_q;
    assign p_o     = p_q;
    assign c_o     = c_q;
    assign last_o  = last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            p_q     <= '0;
            c_q     <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                p_q    <= p_d;
                c_q    <= c_i;
                last_q <= last_i;
            end
        end
    end
endmodule

// File: rtl/mac_engine.sv
// mac_engine: two-stage multiply-add / accumulate engine with valid/ready streams.
// MAC_ENGINE_SATURATE_EN (in mac_engine_pkg / mac_engine_mult) selects saturating arithmetic.
module mac_engine
    import mac_engine_pkg::*;
#(
    parameter int unsigned CNT_LEN = MAC_ENGINE_CNT_LEN
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          test_mode_i,
    input  logic          enable_i,
    input  logic          clear_i,
    input  stream_t       a_i,
    output logic          a_ready_o,
    input  stream_t       b_i,
    output logic          b_ready_o,
    input  stream_t       c_i,
    output logic          c_ready_o,
    output stream_t       d_o,
    input  logic          d_ready_i,
    input  ctrl_engine_t  ctrl_i,
    output flags_engine_t flags_o
);
    mac_engine_state_t  state_q;
    logic               madd_q, done_q, d_valid_q;
    logic [4:0]         shift_q;
    logic [CNT_LEN-1:0] len_q, cnt_q;
    logic [31:0]        acc_q, d_data_q;

    logic        in_valid, in_fire, last_in, s1_ready, s1_valid, s1_last, s2_ready, s2_fire;
    logic [31:0] s1_p, s1_c, sum;
    logic        unused_ok;

    assign unused_ok = ^{test_mode_i, a_i.strb, b_i.strb, c_i.strb};

    assign in_valid  = (state_q == RUN) & ~clear_i & a_i.valid & b_i.valid & (c_i.valid | ~madd_q);
    assign in_fire   = in_valid & s1_ready;
    assign last_in   = (cnt_q + 1'b1) == len_q;
    assign a_ready_o = in_fire;
    assign b_ready_o = in_fire;
    assign c_ready_o = in_fire & madd_q;

    mac_engine_mult u_mult (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .clear_i  (clear_i),
        .valid_i  (in_valid),
        .ready_o  (s1_ready),
        .a_i      (a_i.data),
        .b_i      (b_i.data),
        .c_i      (c_i.data),
        .shift_i  (shift_q),
        .last_i   (last_in),
        .valid_o  (s1_valid),
        .ready_i  (s2_ready),
        .p_o      (s1_p),
        .c_o      (s1_c),
        .last_o   (s1_last)
    );

    assign s2_ready = enable_i & (~d_valid_q | d_ready_i);
    assign s2_fire  = s1_valid & s2_ready;
    assign sum      = add32(madd_q ? s1_c : acc_q, s1_p);

    assign d_o     = '{data: d_data_q, strb: 4'hF, valid: d_valid_q};
    assign flags_o = '{busy: state_q != IDLE, done: done_q, cnt: cnt_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            madd_q    <= 1'b0;
            shift_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            d_valid_q <= 1'b0;
            d_data_q  <= '0;
        end else if (clear_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            d_valid_q <= 1'b0;
            d_data_q  <= '0;
        end else if (enable_i) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (ctrl_i.start) begin
                    madd_q  <= ctrl_i.simple_mul;
                    shift_q <= ctrl_i.shift;
                    len_q   <= ctrl_i.len;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    if (ctrl_i.len == '0) done_q <= 1'b1;
                    else state_q <= RUN;
                end
                RUN: if (in_fire) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_in) state_q <= DRAIN;
                end
                DRAIN: if (!s1_valid && !d_valid_q) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (d_ready_i) d_valid_q <= 1'b0;
            // accumulate mode only emits on the element tagged last in stage 1
            if (s2_fire && (madd_q || s1_last)) begin
                d_valid_q <= 1'b1;
                d_data_q  <= sum;
            end
            if (s2_fire && !madd_q) acc_q <= sum;
        end
    end
endmodule

// File: tb/tb_mac_engine.sv
// tb_mac_engine: randomized self-checking bench for mac_engine against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mac_engine;
    import mac_engine_pkg::*;

    logic          clk_i = 1'b0, rst_ni = 1'b0, test_mode_i = 1'b0, enable_i = 1'b1, clear_i = 1'b0;
    stream_t       a_i, b_i, c_i, d_o;
    logic          a_ready_o, b_ready_o, c_ready_o, d_ready_i;
    ctrl_engine_t  ctrl_i;
    flags_engine_t flags_o;

    int n_vec = 0, n_err = 0;
    int ga[$], gb[$], gc[$];

    always #5 clk_i = ~clk_i;

    mac_engine dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode_i),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .a_i         (a_i),
        .a_ready_o   (a_ready_o),
        .b_i         (b_i),
        .b_ready_o   (b_ready_o),
        .c_i         (c_i),
        .c_ready_o   (c_ready_o),
        .d_o         (d_o),
        .d_ready_i   (d_ready_i),
        .ctrl_i      (ctrl_i),
        .flags_o     (flags_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input longint x);
`ifdef MAC_ENGINE_SATURATE_EN
        longint lo = -64'sd2147483648;
        if (x > 64'sd2147483647) return 32'h7FFFFFFF;
        if (x < lo) return 32'h80000000;
`endif
        return int'(x);
    endfunction

    function automatic int prod(input int a, input int b, input int s);
        longint p = longint'(a) * longint'(b);
        return clamp(p >>> s);
    endfunction

    function automatic int addf(input int x, input int y);
        return clamp(longint'(x) + longint'(y));
    endfunction

    task automatic idle_inputs();
        a_i       = '{data: 32'd0, strb: 4'hF, valid: 1'b0};
        b_i       = '{data: 32'd0, strb: 4'hF, valid: 1'b0};
        c_i       = '{data: 32'd0, strb: 4'hF, valid: 1'b0};
        ctrl_i    = '0;
        d_ready_i = 1'b0;
        enable_i  = 1'b1;
        clear_i   = 1'b0;
    endtask

    task automatic fill(input int n);
        ga.delete(); gb.delete(); gc.delete();
        for (int i = 0; i < n; i++) begin
            ga.push_back($urandom_range(3) == 0 ? int'($urandom) : int'($urandom_range(2000)) - 1000);
            gb.push_back($urandom_range(3) == 0 ? int'($urandom) : int'($urandom_range(2000)) - 1000);
            gc.push_back(int'($urandom));
        end
    endtask

    // rdy_pct < 0 toggles d_ready every cycle
    task automatic run_job(input string nm, input bit madd, input int sh, input int vld_pct,
                           input int rdy_pct, input int en_pct);
        int exp[$];
        int acc = 0, len = ga.size(), idx = 0, got = 0, dones = 0, cyc = 0, post = 0;
        bit stall = 0, cr_seen = 0, v;
        logic [31:0] held = '0;
        for (int i = 0; i < len; i++) begin
            if (madd) exp.push_back(addf(prod(ga[i], gb[i], sh), gc[i]));
            else acc = addf(acc, prod(ga[i], gb[i], sh));
        end
        if (!madd && len > 0) exp.push_back(acc);
        while (post < 3 && cyc < 2000) begin
            @(negedge clk_i);
            ctrl_i   = '{start: (cyc == 0), simple_mul: madd, shift: 5'(sh), len: len[MAC_ENGINE_CNT_LEN-1:0]};
            enable_i = (cyc == 0) || flags_o.done || ($urandom_range(99) < en_pct);
            v        = ($urandom_range(99) < vld_pct) && (idx < len);
            a_i = '{data: v ? ga[idx] : 0, strb: 4'hF, valid: v};
            b_i = '{data: v ? gb[idx] : 0, strb: 4'hF, valid: v};
            c_i = '{data: v ? gc[idx] : 0, strb: 4'hF, valid: v};
            d_ready_i = enable_i && (rdy_pct < 0 ? cyc[0] : ($urandom_range(99) < rdy_pct));
            #1;
            if (stall) begin
                check({nm, " hold valid"}, 32'(d_o.valid), 32'd1);
                check({nm, " hold data"}, d_o.data, held);
            end
            if (!enable_i) check({nm, " ready while disabled"}, 32'(a_ready_o), 32'd0);
            if (cyc == 1) check({nm, " busy after start"}, 32'(flags_o.busy), 32'(len > 0));
            if (!madd && c_ready_o) cr_seen = 1;
            if (d_o.valid && d_ready_i) begin
                check({nm, " d"}, d_o.data, got < exp.size() ? exp[got] : 32'hDEADBEEF);
                got++;
            end
            stall = d_o.valid && !d_ready_i;
            held  = d_o.data;
            if (a_ready_o && a_i.valid) idx++;
            if (flags_o.done) dones++;
            if (dones > 0) post++;
            cyc++;
        end
        check({nm, " d count"}, got, exp.size());
        check({nm, " inputs taken"}, idx, len);
        check({nm, " done pulses"}, dones, 1);
        check({nm, " cnt"}, 32'(flags_o.cnt), len);
        check({nm, " busy end"}, 32'(flags_o.busy), 32'd0);
        if (!madd) check({nm, " c_ready in acc"}, 32'(cr_seen), 32'd0);
        idle_inputs();
    endtask

    initial begin
        int n;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        check("reset d_valid", 32'(d_o.valid), 32'd0);
        check("reset d_data", d_o.data, 32'd0);
        check("reset readies", 32'({a_ready_o, b_ready_o, c_ready_o}), 32'd0);
        check("reset flags", 32'(flags_o), 32'd0);
        rst_ni = 1'b1;

        ga = '{2, -3, 7}; gb = '{5, 4, 1}; gc = '{1, 1, 1};
        run_job("madd3", 1'b1, 0, 100, 100, 100);
        ga = '{4, 4, 4, 4}; gb = '{3, 3, 3, 3}; gc = '{0, 0, 0, 0};
        run_job("acc4", 1'b0, 1, 100, 100, 100);
        fill(8);
        run_job("madd8 toggle", 1'b1, 0, 100, -1, 100);
        ga = '{32'h7FFFFFFF, 32'h7FFFFFFF}; gb = '{32'h7FFFFFFF, 32'h7FFFFFFF}; gc = '{0, 0};
        run_job("acc max", 1'b0, 0, 100, 100, 100);
        fill(0);
        run_job("len0", 1'b1, 0, 100, 100, 100);

        fill(5);
        n = 0;
        @(negedge clk_i);
        ctrl_i = '{start: 1'b1, simple_mul: 1'b1, shift: 5'd0, len: 16'd5};
        for (int k = 0; k < 40 && n < 2; k++) begin
            a_i = '{data: ga[n], strb: 4'hF, valid: 1'b1};
            b_i = '{data: gb[n], strb: 4'hF, valid: 1'b1};
            c_i = '{data: gc[n], strb: 4'hF, valid: 1'b1};
            d_ready_i = 1'b1;
            #1;
            if (a_ready_o) n++;
            @(negedge clk_i);
            ctrl_i.start = 1'b0;
        end
        check("clear reached 2", n, 2);
        idle_inputs();
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        #1;
        check("clear busy", 32'(flags_o.busy), 32'd0);
        check("clear d_valid", 32'(d_o.valid), 32'd0);
        check("clear cnt", 32'(flags_o.cnt), 32'd0);
        fill(1);
        run_job("after clear", 1'b1, 0, 100, 100, 100);

        fill(4);
        @(negedge clk_i);
        ctrl_i = '{start: 1'b1, simple_mul: 1'b1, shift: 5'd0, len: 16'd4};
        a_i.valid = 1'b1; b_i.valid = 1'b1; c_i.valid = 1'b1;
        @(negedge clk_i);
        ctrl_i.start = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("async rst d_valid", 32'(d_o.valid), 32'd0);
        check("async rst d_data", d_o.data, 32'd0);
        check("async rst flags", 32'(flags_o), 32'd0);
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            d_ready_i = 1'b1;
            #1 check("no d after rst", 32'(d_o.valid), 32'd0);
        end
        idle_inputs();

        for (int j = 0; j < 12; j++) begin
            fill($urandom_range(1, 12));
            run_job($sformatf("rand%0d", j), 1'($urandom_range(1)), $urandom_range(31),
                    $urandom_range(50, 100), $urandom_range(30, 100), $urandom_range(70, 100));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
